// File: rtl/fp_mul_pipe_if.sv
// Handshake and operand/result bundle for the pipelined floating-point multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         underflow;
    logic         invalid;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, invalid
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE-754 multiplier (unpack/multiply, normalise/round-to-nearest-even, pack/exceptions).
// Optional sticky exception flags are built when FP_MUL_STICKY_FLAGS_EN is defined.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic         clk,
    input logic         rst_n,
    fp_mul_pipe_if.slave bus
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    input  logic        flags_clr,
    output logic [2:0]  flags_sticky
`endif
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic [XW-1:0]        BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    logic out_valid_q;

    // Every stage moves together; a full output register with no taker freezes the whole pipe.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // ---------------- Stage 1: unpack, classify, multiply ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign ea = bus.a[W-2:MAN_W];
    assign eb = bus.b[W-2:MAN_W];
    assign fa = bus.a[MAN_W-1:0];
    assign fb = bus.b[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    logic                 s1_valid, s1_sign, s1_nan, s1_zinf, s1_inf, s1_zero;
    logic signed [XW-1:0] s1_exp;
    logic [PW-1:0]        s1_prod;

    // ---------------- Stage 2: normalise and round ----------------
    logic             msb, guard, sticky, round_up, carry;
    logic [MAN_W-1:0] frac_t, frac_r;
    logic [XW-1:0]    exp_n;

    always_comb begin
        msb = s1_prod[PW-1];
        if (msb) begin
            frac_t = s1_prod[PW-2 -: MAN_W];
            guard  = s1_prod[MAN_W];
            sticky = |s1_prod[MAN_W-1:0];
        end else begin
            frac_t = s1_prod[PW-3 -: MAN_W];
            guard  = s1_prod[MAN_W-1];
            sticky = |s1_prod[MAN_W-2:0];
        end
        round_up        = guard && (sticky || frac_t[0]);
        // An all-ones fraction that rounds up wraps to zero; the carry moves into the exponent.
        {carry, frac_r} = {1'b0, frac_t} + (MAN_W + 1)'(round_up);
        exp_n           = s1_exp + XW'(msb) + XW'(carry);
    end

    logic                 s2_valid, s2_sign, s2_nan, s2_zinf, s2_inf, s2_zero;
    logic signed [XW-1:0] s2_exp;
    logic [MAN_W-1:0]     s2_frac;

    // ---------------- Stage 3: pack and resolve exceptions ----------------
    logic [W-1:0] res_d;
    logic         ovf_d, unf_d, inv_d;

    // NOTE: every output of a combinational block is given a default first so no path infers a latch.
    always_comb begin
        res_d = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
        if (s2_nan) begin
            res_d = QNAN;
        end else if (s2_zinf) begin
            res_d = QNAN;
            inv_d = 1'b1;
        end else if (s2_inf) begin
            res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero) begin
            res_d = {s2_sign, {(W-1){1'b0}}};
        end else if (s2_exp >= EXP_OVF) begin
            res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else if (s2_exp[XW-1] || (s2_exp == '0)) begin
            res_d = {s2_sign, {(W-1){1'b0}}};
            unf_d = 1'b1;
        end
    end

    logic [W-1:0] result_q;
    logic         ovf_q, unf_q, inv_q;

    // Control and output registers: cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else if (adv) begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
            result_q    <= res_d;
            ovf_q       <= s2_valid && ovf_d;
            unf_q       <= s2_valid && unf_d;
            inv_q       <= s2_valid && inv_d;
        end
    end

    // NOTE: datapath registers carry no reset; their contents are meaningless unless the
    // matching valid bit is set, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= bus.a[W-1] ^ bus.b[W-1];
            s1_nan  <= a_nan || b_nan;
            s1_zinf <= (a_zero && b_inf) || (a_inf && b_zero);
            s1_inf  <= a_inf || b_inf;
            s1_zero <= a_zero || b_zero;
            s1_exp  <= $signed({2'b00, ea} + {2'b00, eb} - BIAS);
            s1_prod <= {1'b1, fa} * {1'b1, fb};

            s2_sign <= s1_sign;
            s2_nan  <= s1_nan;
            s2_zinf <= s1_zinf;
            s2_inf  <= s1_inf;
            s2_zero <= s1_zero;
            s2_exp  <= $signed(exp_n);
            s2_frac <= frac_r;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.invalid   = inv_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [2:0] sticky_q;

    // A flag delivered in the same cycle as a clear survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else begin
            sticky_q <= (flags_clr ? 3'b000 : sticky_q)
                      | ((out_valid_q && bus.out_ready) ? {inv_q, ovf_q, unf_q} : 3'b000);
        end
    end

    assign flags_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32): directed vectors, backpressure, random traffic
// against an integer reference model, mid-flight reset, and sticky flags when enabled.
module tb_fp_mul_pipe;
    localparam int E = 8;
    localparam int M = 23;
    localparam int W = 1 + E + M;

    logic clk = 1'b0;
    logic rst_n;
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic       flags_clr;
    logic [2:0] flags_sticky;
`endif

    fp_mul_pipe_if #(.EXP_W(E), .MAN_W(M)) bus ();

    fp_mul_pipe #(.EXP_W(E), .MAN_W(M)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef FP_MUL_STICKY_FLAGS_EN
        ,
        .flags_clr    (flags_clr),
        .flags_sticky (flags_sticky)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_out    = 0;
    logic [W+2:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer product, remainder-based round-to-nearest-even, then exception rules.
    function automatic logic [W+2:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic         sgn;
        int           ex, ey, e, sh, emax, bias;
        longint       fx, fy, p, q, rem, half;
        logic [W-1:0] qnan, inf, zero;
        bit           xz, yz, xi, yi, xn, yn;
        sgn  = x[W-1] ^ y[W-1];
        ex   = int'(x[W-2:M]);
        ey   = int'(y[W-2:M]);
        fx   = longint'(x[M-1:0]);
        fy   = longint'(y[M-1:0]);
        emax = (1 << E) - 1;
        bias = (1 << (E - 1)) - 1;
        qnan = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        inf  = {sgn, {E{1'b1}}, {M{1'b0}}};
        zero = {sgn, {(W-1){1'b0}}};
        xz = (ex == 0);  yz = (ey == 0);
        xi = (ex == emax) && (fx == 0);  yi = (ey == emax) && (fy == 0);
        xn = (ex == emax) && (fx != 0);  yn = (ey == emax) && (fy != 0);
        if (xn || yn) return {qnan, 3'b000};
        if ((xz && yi) || (xi && yz)) return {qnan, 3'b001};
        if (xi || yi) return {inf, 3'b000};
        if (xz || yz) return {zero, 3'b000};
        p  = ((longint'(1) << M) + fx) * ((longint'(1) << M) + fy);
        e  = ex + ey - bias;
        sh = M;
        if (p >= (longint'(1) << (2 * M + 1))) begin
            sh = M + 1;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == (longint'(1) << (M + 1))) begin
            q = q >> 1;
            e++;
        end
        if (e >= emax) return {inf, 3'b100};
        if (e <= 0) return {zero, 3'b010};
        return {sgn, e[E-1:0], q[M-1:0], 3'b000};
    endfunction

    function automatic logic [W-1:0] rand_op();
        int         k;
        logic       s;
        logic [E-1:0] ee;
        logic [M-1:0] f;
        k  = $urandom_range(0, 9);
        s  = 1'($urandom);
        f  = M'($urandom);
        ee = E'($urandom_range(100, 154));
        case (k)
            0: ee = '0;
            1: begin ee = '1; f = '0; end
            2: begin ee = '1; f[0] = 1'b1; end
            3: ee = E'($urandom);
            4: ee = E'($urandom_range(1, 20));
            5: ee = E'($urandom_range(230, 254));
            default: ;
        endcase
        return {s, ee, f};
    endfunction

    // Presents one pair and holds it until accepted; leaves in_valid high for back-to-back issue.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W+2:0] expd);
        int t;
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        t            = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(expd);
                break;
            end
            t++;
            if (t > 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: got 0 for %0d cycles, expected 1", t);
                break;
            end
        end
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
        step();
    endtask

    // Monitor: protocol checks every cycle and scoreboard comparison on each output handshake.
    initial begin
        logic [W+2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready_adv", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
                if (!bus.out_valid) begin
                    check("idle_flags", {61'd0, bus.overflow, bus.underflow, bus.invalid}, 64'd0);
                end else if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.result);
                    end else begin
                        e = sb.pop_front();
                        check("result_flags",
                              64'({bus.result, bus.overflow, bus.underflow, bus.invalid}), 64'(e));
                        n_out++;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+2:0] r;
    } vec_t;

    vec_t dir[$];
    bit   rnd_done;

    initial begin
        int lat;
        int n0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
`ifdef FP_MUL_STICKY_FLAGS_EN
        flags_clr     = 1'b0;
`endif
        repeat (2) step();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", {61'd0, bus.overflow, bus.underflow, bus.invalid}, 64'd0);
        step();
        rst_n = 1'b1;

        // First transaction: latency from acceptance to out_valid.
        send(32'h3FC00000, 32'h40000000, {32'h40400000, 3'b000});
        idle();
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        step();

        dir.push_back('{32'h3F800800, 32'h3F800800, {32'h3F801000, 3'b000}});
        dir.push_back('{32'h3F800001, 32'h3F800001, {32'h3F800002, 3'b000}});
        dir.push_back('{32'h7F000000, 32'h7F000000, {32'h7F800000, 3'b100}});
        dir.push_back('{32'h00800000, 32'h00800000, {32'h00000000, 3'b010}});
        dir.push_back('{32'h80000000, 32'h7F800000, {32'h7FC00000, 3'b001}});
        dir.push_back('{32'h7FC00001, 32'h3F800000, {32'h7FC00000, 3'b000}});
        dir.push_back('{32'h3FFFFFFF, 32'h3F800001, {32'h40000000, 3'b000}});
        dir.push_back('{32'hBF800000, 32'h40000000, {32'hC0000000, 3'b000}});
        dir.push_back('{32'h7F800000, 32'hC0000000, {32'hFF800000, 3'b000}});
        dir.push_back('{32'h80000000, 32'h3F800000, {32'h80000000, 3'b000}});
        foreach (dir[i]) send(dir[i].a, dir[i].b, dir[i].r);
        idle();
        drain();

        // Backpressure: six back-to-back pairs, out_ready low for 4 cycles starting at cycle 3.
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [W-1:0] x, y;
                    x = {1'b0, 8'(120 + i), 23'($urandom)};
                    y = {1'($urandom), 8'(130 - i), 23'($urandom)};
                    send(x, y, ref_mul(x, y));
                end
                idle();
            end
            begin
                repeat (3) step();
                bus.out_ready = 1'b0;
                repeat (4) step();
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_out - n0), 64'd6);

        // Random traffic with random gaps and random consumer stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [W-1:0] x, y;
                    if ($urandom_range(0, 4) == 0) begin
                        idle();
                        step();
                    end
                    x = rand_op();
                    y = rand_op();
                    send(x, y, ref_mul(x, y));
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Reset with two operations in flight: both must vanish.
        send(32'h3F800000, 32'h40400000, {32'h40400000, 3'b000});
        send(32'h40000000, 32'h40000000, {32'h40800000, 3'b000});
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (10) @(negedge clk);
        step();

`ifdef FP_MUL_STICKY_FLAGS_EN
        send(32'h7F000000, 32'h7F000000, {32'h7F800000, 3'b100});
        send(32'h00000000, 32'hFF800000, {32'h7FC00000, 3'b001});
        idle();
        drain();
        check("sticky_ovf_inv", 64'(flags_sticky), 64'b110);
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        @(negedge clk);
        check("sticky_clr", 64'(flags_sticky), 64'b000);
        step();
        send(32'h7F000000, 32'h7F000000, {32'h7F800000, 3'b100});
        idle();
        drain();
        check("sticky_ovf", 64'(flags_sticky), 64'b010);
        bus.out_ready = 1'b0;
        send(32'h00800000, 32'h00800000, {32'h00000000, 3'b010});
        idle();
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        step();
        bus.out_ready = 1'b1;
        flags_clr     = 1'b1;
        step();
        flags_clr = 1'b0;
        @(negedge clk);
        check("sticky_clr_set", 64'(flags_sticky), 64'b001);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier with valid/ready handshake on input and output.
- Successor to the team's combinational single-precision multiplier.
- Adds generic exponent/mantissa widths, round-to-nearest-even, correct NaN/Inf/zero handling, an invalid flag, and backpressure.
- Sits between the FPU operand-issue logic and the result writeback arbiter.

Parameters:
- EXP_W, 8: exponent field width (≥3).
- MAN_W, 23: stored fraction width (≥2); operand/result width is 1+EXP_W+MAN_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block accepts an operand pair this cycle.
- a  input  1+EXP_W+MAN_W  operand A.
- b  input  1+EXP_W+MAN_W  operand B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  1+EXP_W+MAN_W  packed product.
- overflow  output  1  finite result too large; result is signed Inf.
- underflow  output  1  nonzero result too small for a normal; result is signed zero.
- invalid  output  1  0×Inf; result is canonical qNaN.

Behaviour:
- Reset (rst_n=0 at an edge): all stage valid bits, out_valid, result, overflow, underflow and invalid go to 0; in-flight operations are discarded. No reset is applied to datapath-only registers beyond these.
- Advance enable: adv = !out_valid | out_ready. When adv=1, every stage shifts one step forward (bubbles included). When adv=0, all stages hold.
- in_ready = adv; it is combinational from out_ready and out_valid. An operand pair transfers when in_valid & in_ready.
- Latency is exactly 3 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 per cycle. No loss or reordering under any stall pattern.
- Stage 1 (unpack/classify/multiply):
  - Sign = sA^sB.
  - Class per operand: zero (exp=0, any fraction; subnormals flush to zero), Inf (exp all-ones, frac=0), NaN (exp all-ones, frac≠0), normal.
  - Hidden bit 1 prepended; (MAN_W+1)×(MAN_W+1) product computed.
  - Biased exponent sum Ea+Eb−BIAS computed in signed EXP_W+2 bits, where BIAS = 2^(EXP_W−1)−1.
- Stage 2 (normalise/round):
  - If product MSB is set, shift right 1 and increment the exponent.
  - Keep MAN_W fraction bits, a guard bit G, and sticky S = OR of all lower bits.
  - Round to nearest even: increment when G & (S | LSB).
  - A rounding carry out of the fraction renormalises: fraction becomes 0 and the exponent increments.
- Stage 3 (pack/exceptions), priority order:
  1. Any NaN operand → canonical qNaN {0, all-ones, 1, zeros}; invalid=0.
  2. Zero×Inf → canonical qNaN; invalid=1.
  3. Any Inf → {sign, all-ones, 0}.
  4. Any zero → {sign, 0}.
  5. Exponent ≥ 2^EXP_W−1 → {sign, all-ones, 0}; overflow=1.
  6. Exponent ≤ 0 → {sign, 0}; underflow=1.
  7. Otherwise → {sign, exp[EXP_W−1:0], fraction}.
- At most one flag is set per result. Flags are valid only with out_valid and are 0 otherwise.

Optional Feature:
- Macro FP_MUL_STICKY_FLAGS_EN.
- Defined:
  - Adds input flags_clr (1 bit) and output flags_sticky (3 bits: {invalid, overflow, underflow}).
  - Each bit sets on any output handshake (out_valid & out_ready) carrying that flag.
  - flags_clr=1 clears the register; a clear and a set in the same cycle leave the bit set.
  - Reset value is 0.
- Undefined: these ports and the register do not exist; all other behaviour is identical.

Test Plan:
- EXP_W=8/MAN_W=23, out_ready=1: a=0x3FC00000, b=0x40000000 → 3 cycles later result=0x40400000, all flags 0.
- RNE tie: a=b=0x3F800800 → result=0x3F801000 (exact half-ulp rounds to even). a=b=0x3F800001 → result=0x3F800002.
- Exceptions:
  - 0x7F000000×0x7F000000 → 0x7F800000, overflow=1.
  - 0x00800000×0x00800000 → 0x00000000, underflow=1.
  - 0x80000000×0x7F800000 → 0x7FC00000, invalid=1.
  - 0x7FC00001×0x3F800000 → 0x7FC00000, invalid=0.
- Backpressure: issue 6 back-to-back pairs, drop out_ready for 4 cycles at cycle 3 → in_ready follows adv; all 6 results emerge in order with no duplicates or loss.
- Reset mid-flight: 2 operations in pipe, rst_n=0 for one edge → out_valid=0 next cycle; no stale result appears later.
- With FP_MUL_STICKY_FLAGS_EN: overflow then invalid results → flags_sticky=3'b110. Pulse flags_clr → 3'b000. Clear coincident with an underflow handshake → 3'b001.
